matmul_seq_ctrl: RTL and testbench

Streaming front-end and sequencer for the matmul_top datapath (three BRAMs plus matmul core).
- Accepts A then B elements on one valid/ready input stream and writes them into BRAM A/B.
- Pulses start and waits for done.
- Streams C out of BRAM C on a valid/ready output stream, then re-arms for the next matrix pair.

---
 rtl/matmul_seq_ctrl_pkg.sv | 16 +
 rtl/matmul_seq_ctrl_if.sv | 22 ++
 rtl/matmul_seq_ctrl_skid_fifo.sv | 56 +++++
 rtl/matmul_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types for the matmul sequencer: controller state encoding and element-count helper.
package matmul_pkg;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    DRAIN
  } state_t;

  function automatic int calc_ne(input int matrix_size);
    return matrix_size * matrix_size;
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Input element stream and output C stream of the matmul sequencer, bundled as valid/ready pairs.
interface matmul_seq_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_din;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_dout;
  logic                  out_valid;
  logic                  out_ready;

  // master: external producer of A/B and consumer of C; slave: the sequencer
  modport master (
    output in_din, in_valid, out_ready,
    input  in_ready, out_dout, out_valid
  );

  modport slave (
    input  in_din, in_valid, out_ready,
    output in_ready, out_dout, out_valid
  );
endinterface

// File: rtl/matmul_seq_ctrl_skid_fifo.sv
// Two-entry FIFO buffering BRAM C read data ahead of the output stream.
module matmul_skid_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_empty,
  output logic [1:0]            o_count
);
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_din;
          else                 r_tail <= i_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // head leaves while a new word arrives; it lands behind whatever remains
          if (r_count == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dout  = r_head;
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
endmodule

// File: rtl/matmul_seq_ctrl.sv
// Loads A then B into BRAM, kicks the matmul core, then streams C back out.
// Optional MATMUL_SEQ_CTRL_PERF_EN adds a compute_cycles counter of WAIT cycles.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int MATRIX_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  matmul_seq_ctrl_if.slave      stream,
  output logic [DATA_WIDTH-1:0] a_wr_din,
  output logic [ADDR_WIDTH-1:0] a_wr_addr,
  output logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] b_wr_din,
  output logic [ADDR_WIDTH-1:0] b_wr_addr,
  output logic                  b_wr_en,
  output logic                  start,
  input  logic                  done,
  output logic [ADDR_WIDTH-1:0] c_rd_addr,
  input  logic [DATA_WIDTH-1:0] c_rd_dout,
  output logic                  busy
`ifdef MATMUL_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]           compute_cycles
`endif
);
  localparam int NE = calc_ne(MATRIX_SIZE);
  localparam int CW = $clog2(NE + 1);

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [CW-1:0]   r_rd_cnt, w_rd_cnt_next;
  logic [CW-1:0]   r_out_cnt, w_out_cnt_next;
  logic            r_wait_armed, w_wait_armed_next;
  logic            r_inflight;
  logic            r_start;
  logic            r_busy;
  logic [ADDR_WIDTH-1:0] r_c_rd_addr;

  logic            w_loading;
  logic            w_accept;
  logic            w_last_in;
  logic            w_pop;
  logic            w_issue;
  logic [1:0]      w_credits;
  logic            w_fifo_empty;
  logic [1:0]      w_fifo_count;
  logic [DATA_WIDTH-1:0] w_fifo_head;

  assign w_loading       = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign stream.in_ready = !reset && w_loading;
  assign w_accept        = stream.in_valid && stream.in_ready;
  assign w_last_in       = (r_cnt == CW'(NE - 1));

  assign a_wr_en   = w_accept && (r_state == LOAD_A);
  assign a_wr_addr = ADDR_WIDTH'(r_cnt);
  assign a_wr_din  = stream.in_din;
  assign b_wr_en   = w_accept && (r_state == LOAD_B);
  assign b_wr_addr = ADDR_WIDTH'(r_cnt);
  assign b_wr_din  = stream.in_din;

  // credits = words held + read in flight; a same-cycle pop frees one
  assign w_pop     = (r_state == DRAIN) && !w_fifo_empty && stream.out_ready;
  assign w_credits = w_fifo_count + {1'b0, r_inflight};
  assign w_issue   = (r_state == DRAIN) && (r_rd_cnt < CW'(NE))
                     && ((w_credits - {1'b0, w_pop}) < 2'd2);

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_rd_cnt_next     = r_rd_cnt;
    w_out_cnt_next    = r_out_cnt;
    w_wait_armed_next = r_wait_armed;
    case (r_state)
      LOAD_A, LOAD_B: begin
        if (w_accept) begin
          if (w_last_in) begin
            w_cnt_next   = '0;
            w_state_next = (r_state == LOAD_A) ? LOAD_B : START;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      START: begin
        w_state_next      = WAIT;
        w_wait_armed_next = 1'b0;
      end
      WAIT: begin
        // the first WAIT cycle may still see done from the previous run
        if (!r_wait_armed) begin
          w_wait_armed_next = 1'b1;
        end else if (done) begin
          w_state_next   = DRAIN;
          w_rd_cnt_next  = '0;
          w_out_cnt_next = '0;
        end
      end
      DRAIN: begin
        if (w_issue) w_rd_cnt_next = r_rd_cnt + CW'(1);
        if (w_pop) begin
          w_out_cnt_next = r_out_cnt + CW'(1);
          if (r_out_cnt == CW'(NE - 1)) begin
            w_state_next = LOAD_A;
            w_cnt_next   = '0;
          end
        end
      end
      default: w_state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= LOAD_A;
      r_cnt        <= '0;
      r_rd_cnt     <= '0;
      r_out_cnt    <= '0;
      r_wait_armed <= 1'b0;
      r_inflight   <= 1'b0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_c_rd_addr  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_rd_cnt     <= w_rd_cnt_next;
      r_out_cnt    <= w_out_cnt_next;
      r_wait_armed <= w_wait_armed_next;
      r_inflight   <= w_issue;
      r_start      <= (w_state_next == START);
      r_busy       <= !((w_state_next == LOAD_A) && (w_cnt_next == '0));
      // c_rd_addr always presents the read that would issue this cycle
      if (w_state_next == DRAIN) r_c_rd_addr <= ADDR_WIDTH'(w_rd_cnt_next);
    end
  end

  matmul_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_fifo (
    .clk     (clock),
    .srst    (reset),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   (c_rd_dout),
    .o_dout  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign stream.out_valid = !w_fifo_empty;
  assign stream.out_dout  = w_fifo_head;
  assign start            = r_start;
  assign busy             = r_busy;
  assign c_rd_addr        = r_c_rd_addr;

`ifdef MATMUL_SEQ_CTRL_PERF_EN
  logic [31:0] r_compute_cycles;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_compute_cycles <= '0;
    end else if (w_state_next == START) begin
      r_compute_cycles <= '0;
    end else if ((r_state == WAIT) && (r_compute_cycles != 32'hFFFF_FFFF)) begin
      r_compute_cycles <= r_compute_cycles + 32'd1;
    end
  end

  assign compute_cycles = r_compute_cycles;
`endif
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized bench for matmul_seq_ctrl with BRAM/matmul-core models and a matrix-product reference.
module tb_matmul_seq_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int N  = 8;
  localparam int NE = N * N;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  matmul_seq_ctrl_if #(.DATA_WIDTH(DW)) stream_if ();

  logic [DW-1:0] a_wr_din, b_wr_din;
  logic [AW-1:0] a_wr_addr, b_wr_addr, c_rd_addr;
  logic          a_wr_en, b_wr_en, start, busy;
  logic          done = 1'b0;
  logic [DW-1:0] c_rd_dout = '0;
`ifdef MATMUL_SEQ_CTRL_PERF_EN
  logic [31:0]   compute_cycles;
`endif

  matmul_seq_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MATRIX_SIZE(N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .stream    (stream_if),
    .a_wr_din  (a_wr_din),
    .a_wr_addr (a_wr_addr),
    .a_wr_en   (a_wr_en),
    .b_wr_din  (b_wr_din),
    .b_wr_addr (b_wr_addr),
    .b_wr_en   (b_wr_en),
    .start     (start),
    .done      (done),
    .c_rd_addr (c_rd_addr),
    .c_rd_dout (c_rd_dout),
    .busy      (busy)
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    ,
    .compute_cycles(compute_cycles)
`endif
  );

  // BRAM and matmul core models
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] mem_c [1024];
  int   mm_latency = 10;
  int   mm_left = 0;
  logic mm_run = 1'b0;
  logic clr_d = 1'b0;
  int   start_pulses = 0;

  function automatic logic [DW-1:0] core_dot(input int r, input int c);
    logic [DW-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++) acc = acc + mem_a[r*N+k] * mem_b[k*N+c];
    return acc;
  endfunction

  always @(posedge clock) begin
    if (a_wr_en) mem_a[a_wr_addr] <= a_wr_din;
    if (b_wr_en) mem_b[b_wr_addr] <= b_wr_din;
    c_rd_dout <= mem_c[c_rd_addr];
    if (start) start_pulses <= start_pulses + 1;
    // done stays high until one cycle after the next start, so it is stale in the first WAIT cycle
    clr_d <= start;
    if (clr_d) done <= 1'b0;
    if (start) begin
      mm_run  <= 1'b1;
      mm_left <= mm_latency;
    end else if (mm_run) begin
      mm_left <= mm_left - 1;
      if (mm_left <= 1) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) mem_c[r*N+c] <= core_dot(r, c);
        done   <= 1'b1;
        mm_run <= 1'b0;
      end
    end
  end

  // reference
  logic [DW-1:0] sa [NE];
  logic [DW-1:0] sb [NE];
  logic [DW-1:0] expc [NE];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_ref();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + sa[r*N+k] * sb[k*N+c];
        expc[r*N+c] = s;
      end
  endtask

  task automatic send_all(input bit gaps);
    bit tog;
    tog = 1'b1;
    for (int i = 0; i < 2*NE; i++) begin
      bit acc;
      int waited;
      logic [DW-1:0] v;
      acc    = 1'b0;
      waited = 0;
      v      = (i < NE) ? sa[i] : sb[i-NE];
      while (!acc && waited < 50) begin
        @(negedge clock);
        stream_if.in_valid = gaps ? tog : 1'b1;
        tog = ~tog;
        stream_if.in_din = v;
        #1;
        if (stream_if.in_valid && stream_if.in_ready) begin
          acc = 1'b1;
          if (i < NE) begin
            check("a_wr_en", 64'(a_wr_en), 64'(1));
            check($sformatf("a_wr_addr[%0d]", i), 64'(a_wr_addr), 64'(i));
            check("a_wr_din", 64'(a_wr_din), 64'(v));
            check("b_wr_en_idle", 64'(b_wr_en), 64'(0));
          end else begin
            check("b_wr_en", 64'(b_wr_en), 64'(1));
            check($sformatf("b_wr_addr[%0d]", i-NE), 64'(b_wr_addr), 64'(i-NE));
            check("b_wr_din", 64'(b_wr_din), 64'(v));
            check("a_wr_en_idle", 64'(a_wr_en), 64'(0));
          end
        end
        waited++;
      end
      if (!acc) begin
        check("in_accept", 64'(acc), 64'(1));
        break;
      end
    end
    // input offered during START must be refused
    @(negedge clock);
    stream_if.in_valid = 1'b1;
    stream_if.in_din   = 32'hDEAD_BEEF;
    #1;
    check("in_ready_start", 64'(stream_if.in_ready), 64'(0));
    check("no_write_start", 64'(a_wr_en | b_wr_en), 64'(0));
    check("busy_run", 64'(busy), 64'(1));
    @(negedge clock);
    stream_if.in_valid = 1'b0;
  endtask

  // leaves the bench at the negedge after the stop_at-th pop edge, out_ready low
  task automatic recv(input int rdy_pct, input int stop_at, input bit check_contig);
    int k, cyc, gap_cnt;
    bit held, seen;
    logic [DW-1:0] held_data;
    k = 0; cyc = 0; gap_cnt = 0; held = 0; seen = 0; held_data = '0;
    while (k < stop_at && cyc < 5000) begin
      @(negedge clock);
      stream_if.out_ready = ($urandom_range(99, 0) < rdy_pct);
      #1;
      if (held) begin
        check("bp_valid_hold", 64'(stream_if.out_valid), 64'(1));
        check("bp_data_hold", 64'(stream_if.out_dout), 64'(held_data));
      end
      if (stream_if.out_valid) begin
        seen = 1;
        if (stream_if.out_ready) begin
          check($sformatf("c_out[%0d]", k), 64'(stream_if.out_dout), 64'(expc[k]));
          k++;
          held = 0;
        end else begin
          held      = 1;
          held_data = stream_if.out_dout;
        end
      end else if (seen) begin
        gap_cnt++;
      end
      cyc++;
    end
    check("out_count", 64'(k), 64'(stop_at));
    if (check_contig) check("out_contiguous_gaps", 64'(gap_cnt), 64'(0));
    @(negedge clock);
    stream_if.out_ready = 1'b0;
  endtask

  task automatic full_run(input bit gaps, input int rdy_pct, input bit contig);
    int s0;
    s0 = start_pulses;
    build_ref();
    send_all(gaps);
    recv(rdy_pct, NE, contig);
    #1;
    check("start_once", 64'(start_pulses - s0), 64'(1));
    check("busy_after_last", 64'(busy), 64'(0));
    check("in_ready_after_last", 64'(stream_if.in_ready), 64'(1));
    check("out_valid_after_last", 64'(stream_if.out_valid), 64'(0));
`ifdef MATMUL_SEQ_CTRL_PERF_EN
    check("compute_cycles", 64'(compute_cycles), 64'(mm_latency + 1));
    repeat (5) @(negedge clock);
    check("compute_cycles_hold", 64'(compute_cycles), 64'(mm_latency + 1));
`endif
  endtask

  task automatic rand_fill_a();
    for (int i = 0; i < NE; i++) sa[i] = $urandom();
  endtask

  task automatic rand_fill_b();
    for (int i = 0; i < NE; i++) sb[i] = $urandom();
  endtask

  initial begin
    stream_if.in_din    = '0;
    stream_if.in_valid  = 1'b1;
    stream_if.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_no_write", 64'(a_wr_en | b_wr_en), 64'(0));
    check("reset_in_ready", 64'(stream_if.in_ready), 64'(0));
    @(negedge clock);
    stream_if.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(stream_if.in_ready), 64'(1));
    check("rst_out_valid", 64'(stream_if.out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_start", 64'(start), 64'(0));
    check("rst_c_rd_addr", 64'(c_rd_addr), 64'(0));

    // identity A, ramp B, full-rate output
    for (int i = 0; i < NE; i++) begin
      sa[i] = ((i / N) == (i % N)) ? 32'd1 : 32'd0;
      sb[i] = i;
    end
    mm_latency = $urandom_range(40, 3);
    full_run(1'b0, 100, 1'b1);

    // all-ones by all-twos with toggling in_valid
    for (int i = 0; i < NE; i++) begin
      sa[i] = 32'd1;
      sb[i] = 32'd2;
    end
    mm_latency = $urandom_range(40, 3);
    full_run(1'b1, 100, 1'b0);

    // random data, 50% output backpressure
    rand_fill_a();
    rand_fill_b();
    mm_latency = $urandom_range(40, 3);
    full_run(1'b0, 50, 1'b0);

    // back-to-back pair, second B is 3x the first
    rand_fill_a();
    rand_fill_b();
    mm_latency = $urandom_range(40, 3);
    full_run(1'b0, 70, 1'b0);
    for (int i = 0; i < NE; i++) sb[i] = sb[i] * 32'd3;
    mm_latency = $urandom_range(40, 3);
    full_run(1'b1, 70, 1'b0);

    // reset during DRAIN after 20 pops
    rand_fill_a();
    rand_fill_b();
    mm_latency = $urandom_range(40, 3);
    build_ref();
    send_all(1'b0);
    recv(100, 20, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(stream_if.out_valid), 64'(0));
    check("midrst_in_ready", 64'(stream_if.in_ready), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    rand_fill_b();
    full_run(1'b0, 60, 1'b0);

    // long compute: done lands 600 cycles after start
    rand_fill_a();
    rand_fill_b();
    mm_latency = 599;
    full_run(1'b0, 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
